zbuffer_pipe: RTL and testbench

Pipelined, parametrised per-pixel depth-test unit between the triangle rasteriser and the framebuffer writer. Each accepted fragment (x, y, z) is compared against stored screen-space depth; it is drawn and its depth written back only if strictly nearer. Owns the depth RAM and a hardware clear sequencer that fills it with the far value, replacing .coe/.mif initialisation.

---
 rtl/zbuf_pkg.sv | 18 +
 rtl/zbuf_ram.sv | 28 ++
 rtl/zbuffer_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_zbuffer_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbuf_pkg.sv
// rtl/zbuf_pkg.sv - shared types and helpers for the depth-test pipeline
package zbuf_pkg;

  // Clear sequencer states
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } clr_state_t;

  // Address width for an h_res x v_res depth buffer (at least one bit)
  function automatic int zbuf_addr_w(input int h_res, input int v_res);
    int depth;
    depth = h_res * v_res;
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/zbuf_ram.sv
// rtl/zbuf_ram.sv - simple dual-port inferred depth RAM, read-first, 1-cycle registered read
module zbuf_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read share the edge; a colliding read returns the old word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/zbuffer_pipe.sv
// rtl/zbuffer_pipe.sv - pipelined depth test with owned depth RAM and clear sequencer; ZBUF_FWD_EN selects forwarding over stalling
module zbuffer_pipe
  import zbuf_pkg::*;
#(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int Z_W   = 8,
  parameter int X_W   = 9,
  parameter int Y_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_start,
  output logic           clear_busy,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  input  logic [Z_W-1:0] in_z,
  output logic           out_valid,
  output logic           out_draw,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic [Z_W-1:0] out_z
);

  localparam int               DEPTH  = H_RES * V_RES;
  localparam int               ADDR_W = zbuf_addr_w(H_RES, V_RES);
  localparam logic [Z_W-1:0]   Z_MAX  = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              busy_q;
  logic              idle_q;

  logic              a_valid;
  logic              a_inrange;
  logic [X_W-1:0]    a_x;
  logic [Y_W-1:0]    a_y;
  logic [Z_W-1:0]    a_z;
  logic [ADDR_W-1:0] a_addr;

  logic              b_valid;
  logic              b_inrange;
  logic [X_W-1:0]    b_x;
  logic [Y_W-1:0]    b_y;
  logic [Z_W-1:0]    b_z;
  logic [ADDR_W-1:0] b_addr;

  logic [ADDR_W-1:0] in_addr;
  logic              in_range;
  logic              accept;
  logic              b_pass;
  logic              hazard;
  logic              stall;
  logic [Z_W-1:0]    stored_z;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [Z_W-1:0]    ram_wdata;
  logic              ram_re;
  logic [Z_W-1:0]    ram_rdata;

  assign in_addr  = ADDR_W'(in_y) * ADDR_W'(H_RES) + ADDR_W'(in_x);
  assign in_range = (int'(in_x) < H_RES) && (int'(in_y) < V_RES);
  assign accept   = in_valid && in_ready;

  assign b_pass   = b_valid && b_inrange && (b_z < stored_z);
  // A reads the same word that B is writing on this edge: the RAM would hand back the old value
  assign hazard   = a_valid && a_inrange && b_pass && (a_addr == b_addr);

`ifdef ZBUF_FWD_EN
  logic           b_fwd;
  logic [Z_W-1:0] b_fwd_z;

  assign stall    = 1'b0;
  assign stored_z = b_fwd ? b_fwd_z : ram_rdata;
`else
  assign stall    = hazard;
  assign stored_z = ram_rdata;
`endif

  assign in_ready   = idle_q && !stall;
  assign clear_busy = busy_q;
  assign ram_re     = a_valid && a_inrange && !stall;

  // Write port: clear sequencer owns it while clearing, otherwise the passing fragment in B
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = b_addr;
    ram_wdata = b_z;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = Z_MAX;
    end else if (b_pass) begin
      ram_we = 1'b1;
    end
  end

  zbuf_ram #(
    .DATA_W (Z_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (a_addr),
    .rdata (ram_rdata)
  );

  // Clear sequencer: fill with far depth after reset or on request, draining the pipe first
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
      idle_q  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
            busy_q  <= 1'b0;
            idle_q  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clear_start) begin
            state  <= ST_DRAIN;
            busy_q <= 1'b1;
            idle_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!a_valid && !b_valid) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_cnt <= '0;
          busy_q  <= 1'b1;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage A: capture the accepted fragment and its address; held in place while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
    end else if (!stall) begin
      a_valid <= accept;
      if (accept) begin
        a_x       <= in_x;
        a_y       <= in_y;
        a_z       <= in_z;
        a_addr    <= in_addr;
        a_inrange <= in_range;
      end
    end
  end

  // Stage B: fragment meets its stored depth; a stall inserts a bubble here
  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid <= 1'b0;
`ifdef ZBUF_FWD_EN
      b_fwd   <= 1'b0;
`endif
    end else begin
      b_valid <= a_valid && !stall;
      if (a_valid && !stall) begin
        b_x       <= a_x;
        b_y       <= a_y;
        b_z       <= a_z;
        b_addr    <= a_addr;
        b_inrange <= a_inrange;
      end
`ifdef ZBUF_FWD_EN
      b_fwd   <= hazard;
      b_fwd_z <= b_z;
`endif
    end
  end

  // Result register: one strobe per fragment, registered on the same edge as its write
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_draw  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      out_valid <= b_valid;
      out_draw  <= b_pass;
      if (b_valid) begin
        out_x <= b_x;
        out_y <= b_y;
        out_z <= b_z;
      end
    end
  end

endmodule

// File: tb/tb_zbuffer_pipe.sv
// tb/tb_zbuffer_pipe.sv - scoreboard bench for zbuffer_pipe against a depth-array model
`timescale 1ns/1ps
module tb_zbuffer_pipe;

  localparam int H_RES = 40;
  localparam int V_RES = 24;
  localparam int Z_W   = 8;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int DEPTH = H_RES * V_RES;
`ifdef ZBUF_FWD_EN
  localparam int BURST_STALLS = 0;
`else
  localparam int BURST_STALLS = 2;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clear_start = 1'b0;
  logic           clear_busy;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [X_W-1:0] in_x = '0;
  logic [Y_W-1:0] in_y = '0;
  logic [Z_W-1:0] in_z = '0;
  logic           out_valid;
  logic           out_draw;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic [Z_W-1:0] out_z;

  zbuffer_pipe #(
    .H_RES (H_RES), .V_RES (V_RES), .Z_W (Z_W), .X_W (X_W), .Y_W (Y_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_z        (in_z),
    .out_valid   (out_valid),
    .out_draw    (out_draw),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_z       (out_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit draw;
    int x;
    int y;
    int z;
    int acc;
    bit chk_lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   model_z [DEPTH];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   count_win = 1'b0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: one depth per pixel, strict less-than wins and overwrites
  function automatic bit model_frag(input int x, input int y, input int z);
    int a;
    if (x >= H_RES || y >= V_RES) return 1'b0;
    a = y * H_RES + x;
    if (z < model_z[a]) begin
      model_z[a] = z;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_clear();
    foreach (model_z[i]) model_z[i] = 255;
  endfunction

  // Monitor: pops the scoreboard whenever a result strobe appears
  always @(negedge clk) begin
    if (count_win && !in_ready) stall_cnt++;
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_draw", int'(out_draw), int'(mon_e.draw));
        check("out_x", int'(out_x), mon_e.x);
        check("out_y", int'(out_y), mon_e.y);
        check("out_z", int'(out_z), mon_e.z);
        if (mon_e.chk_lat) check("latency_edges", cyc - mon_e.acc, 3);
      end
    end
  end

  task automatic send(input int x, input int y, input int z, input bit chk_lat);
    int   tries;
    exp_t e;
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = X_W'(x);
    in_y = Y_W'(y);
    in_z = Z_W'(z);
    while (!in_ready && tries < 64) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.draw = model_frag(x, y, z);
    e.x = x;
    e.y = y;
    e.z = z;
    e.acc = cyc;
    e.chk_lat = chk_lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Counts negedges until clear_busy falls; optionally pokes clear_start mid-way
  task automatic wait_clear(input int poke, output int n, output int ready_bad);
    n = 0;
    ready_bad = 0;
    do begin
      @(negedge clk);
      n++;
      clear_start = (n == poke);
      if (clear_busy && in_ready) ready_bad++;
    end while (clear_busy && n < DEPTH + 100);
    clear_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    int x;
    int y;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_draw", int'(out_draw), 0);
    check("rst_out_x", int'(out_x), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_z", int'(out_z), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_clear_busy", int'(clear_busy), 1);
    reset = 1'b0;
    model_clear();
    wait_clear(-1, n, bad);
    check("init_clear_cycles", n, DEPTH);
    check("init_clear_ready_low", bad, 0);
    check("ready_after_clear", int'(in_ready), 1);

    // First fragment and same-pixel sequence
    send(5, 5, 8'h80, 1'b1);
    drain();
    send(5, 5, 8'h40, 1'b0);
    send(5, 5, 8'h40, 1'b0);
    send(5, 5, 8'h50, 1'b0);
    send(5, 5, 8'h3F, 1'b0);
    drain();

    // Back-to-back same address
    stall_cnt = 0;
    count_win = 1'b1;
    send(10, 3, 8'h90, 1'b0);
    send(10, 3, 8'h70, 1'b0);
    send(10, 3, 8'h80, 1'b0);
    drain();
    count_win = 1'b0;
    check("burst_ready_low_cycles", stall_cnt, BURST_STALLS);

    // Out of range leaves the buffer untouched
    send(H_RES, 0, 8'h01, 1'b1);
    send(0, V_RES, 8'h01, 1'b0);
    send(0, 0, 8'hFE, 1'b0);
    send(0, 1, 8'hFE, 1'b0);
    drain();

    // Randomised traffic over a small pixel window
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(0, 3));
      y = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) x = H_RES + int'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) y = V_RES + int'($urandom_range(0, 2));
      send(x, y, int'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    // Clear requested with fragments in flight
    send(7, 7, 8'h10, 1'b0);
    drain();
    send(7, 7, 8'h20, 1'b0);
    send(8, 7, 8'h30, 1'b0);
    @(negedge clk);
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    wait_clear(100, n, bad);
    model_clear();
    check("clear_cycles", n, DEPTH + 3);
    check("clear_ready_low", bad, 0);
    check("clear_queue_empty", exp_q.size(), 0);
    send(7, 7, 8'hFE, 1'b0);
    drain();

    // Reset drops an in-flight fragment
    send(3, 3, 8'h05, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("drop_out_valid", int'(out_valid), 0);
    reset = 1'b0;
    model_clear();
    wait_clear(-1, n, bad);
    check("drop_clear_cycles", n, DEPTH);

    // Reset midway through a clear restarts it from the beginning
    @(negedge clk);
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    repeat (200) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_clear_busy", int'(clear_busy), 1);
    check("midrst_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    model_clear();
    wait_clear(-1, n, bad);
    check("midrst_clear_cycles", n, DEPTH);
    send(3, 3, 8'h05, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
